// File: rtl/ram256_arbiter_if.sv
// Requester-side and RAM-side signals of the two-port RAM256 arbiter.
// slave: arbiter view; master: requesters plus RAM view.
interface ram256_arbiter_if;
    logic       reqA;
    logic       reqB;
    logic       weA;
    logic       weB;
    logic [7:0] addrA;
    logic [7:0] addrB;
    logic [7:0] wdataA;
    logic [7:0] wdataB;
    logic       gntA;
    logic       gntB;
    logic       rvalidA;
    logic       rvalidB;
    logic [7:0] rdata;
    logic [1:0] bankSel;
    logic [3:0] bankWe;
    logic [5:0] ramAddr;
    logic [7:0] ramWdata;
    logic [7:0] ramRdata;

    modport slave (
        input  reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, ramRdata,
        output gntA, gntB, rvalidA, rvalidB, rdata, bankSel, bankWe, ramAddr, ramWdata
    );

    modport master (
        output reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, ramRdata,
        input  gntA, gntB, rvalidA, rvalidB, rdata, bankSel, bankWe, ramAddr, ramWdata
    );
endinterface

// File: rtl/ram256_arbiter.sv
// Round-robin two-requester sequencer in front of a 4x64x8 banked RAM.
// Optional ARB_GRANT_CNT_EN adds saturating per-requester grant counters.
module ram256_arbiter #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    ram256_arbiter_if.slave    bus
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0]   grantCntA,
    output logic [CNT_W-1:0]   grantCntB
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t     state;
    logic       last_b;
    logic       cur_b;
    logic       cur_we;
    logic [1:0] lat_cnt;

    logic       pick_b;
    logic       grant_a;
    logic       grant_b;
    logic       sel_we;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;
    logic [3:0] sel_onehot;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        pick_b    = bus.reqB & (~bus.reqA | ~last_b);
        grant_a   = (state == IDLE) & (bus.reqA | bus.reqB) & ~pick_b;
        grant_b   = (state == IDLE) & pick_b;
        sel_we    = pick_b ? bus.weB    : bus.weA;
        sel_addr  = pick_b ? bus.addrB  : bus.addrA;
        sel_wdata = pick_b ? bus.wdataB : bus.wdataA;
        sel_onehot = '0;
        sel_onehot[sel_addr[7:6]] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_b       <= 1'b1;
            cur_b        <= 1'b0;
            cur_we       <= 1'b0;
            lat_cnt      <= '0;
            bus.gntA     <= 1'b0;
            bus.gntB     <= 1'b0;
            bus.rvalidA  <= 1'b0;
            bus.rvalidB  <= 1'b0;
            bus.rdata    <= '0;
            bus.bankSel  <= '0;
            bus.bankWe   <= '0;
            bus.ramAddr  <= '0;
            bus.ramWdata <= '0;
        end else begin
            bus.gntA    <= 1'b0;
            bus.gntB    <= 1'b0;
            bus.rvalidA <= 1'b0;
            bus.rvalidB <= 1'b0;
            bus.bankWe  <= '0;
            case (state)
                IDLE: begin
                    if (grant_a | grant_b) begin
                        cur_b        <= pick_b;
                        last_b       <= pick_b;
                        cur_we       <= sel_we;
                        lat_cnt      <= '0;
                        bus.gntA     <= grant_a;
                        bus.gntB     <= grant_b;
                        bus.bankSel  <= sel_addr[7:6];
                        bus.ramAddr  <= sel_addr[5:0];
                        bus.ramWdata <= sel_wdata;
                        bus.bankWe   <= sel_we ? sel_onehot : 4'b0000;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cur_we) begin
                        state <= IDLE;
                    end else if (lat_cnt == 2'(RD_LAT)) begin
                        bus.rdata   <= bus.ramRdata;
                        bus.rvalidA <= ~cur_b;
                        bus.rvalidB <= cur_b;
                        state       <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_GRANT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grantCntA <= '0;
            grantCntB <= '0;
        end else begin
            if (grant_a && grantCntA != '1) grantCntA <= grantCntA + 1'b1;
            if (grant_b && grantCntB != '1) grantCntB <= grantCntB + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ram256_arbiter.sv
// Scoreboard bench for ram256_arbiter: directed requests push expected grant/read
// responses, an independent monitor pops and compares them as the DUT produces them.
module tb_ram256_arbiter;
    localparam int unsigned RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram256_arbiter_if bus();

`ifdef ARB_GRANT_CNT_EN
    logic [3:0] grantCntA;
    logic [3:0] grantCntB;
    ram256_arbiter #(.RD_LAT(RD_LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .grantCntA(grantCntA), .grantCntB(grantCntB)
    );
`else
    ram256_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    // Banked RAM model: combinational read, write on the clock edge.
    logic [7:0] mem [256];
    assign bus.ramRdata = mem[{bus.bankSel, bus.ramAddr}];
    always @(posedge clk) begin
        if (bus.bankWe != 4'h0) mem[{bus.bankSel, bus.ramAddr}] <= bus.ramWdata;
    end

    typedef struct packed {
        logic       ga;
        logic       gb;
        logic [1:0] bs;
        logic [3:0] we;
        logic [5:0] ra;
        logic [7:0] wd;
    } gnt_t;

    typedef struct packed {
        logic       va;
        logic       vb;
        logic [7:0] d;
    } rsp_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc = 0;
    int   last_gnt_cyc = 0;
    gnt_t got_g, exp_g;
    rsp_t got_r, exp_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard queues.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.gntA | bus.gntB) begin
                got_g = {bus.gntA, bus.gntB, bus.bankSel, bus.bankWe, bus.ramAddr, bus.ramWdata};
                checks++;
                if (gnt_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_gnt actual=%h required=none", got_g);
                end else begin
                    exp_g = gnt_q.pop_front();
                    if (got_g !== exp_g) begin
                        fails++;
                        $display("FAIL gnt_cmd actual=%h required=%h", got_g, exp_g);
                    end
                end
                last_gnt_cyc = cyc;
            end else begin
                checks++;
                if (bus.bankWe !== 4'h0) begin
                    fails++;
                    $display("FAIL bankwe_no_gnt actual=%h required=0", bus.bankWe);
                end
            end
            if (bus.rvalidA | bus.rvalidB) begin
                got_r = {bus.rvalidA, bus.rvalidB, bus.rdata};
                checks++;
                if (rsp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_rvalid actual=%h required=none", got_r);
                end else begin
                    exp_r = rsp_q.pop_front();
                    if (got_r !== exp_r) begin
                        fails++;
                        $display("FAIL rsp actual=%h required=%h", got_r, exp_r);
                    end
                end
                checks++;
                if (cyc - last_gnt_cyc != 1 + RD_LAT) begin
                    fails++;
                    $display("FAIL rd_latency actual=%0d required=%0d", cyc - last_gnt_cyc, 1 + RD_LAT);
                end
            end
        end
    end

    task automatic set_req(input bit is_b, input bit r, input bit we,
                           input logic [7:0] addr, input logic [7:0] wdata);
        if (is_b) begin
            bus.reqB = r; bus.weB = we; bus.addrB = addr; bus.wdataB = wdata;
        end else begin
            bus.reqA = r; bus.weA = we; bus.addrA = addr; bus.wdataA = wdata;
        end
    endtask

    task automatic push_gnt(input bit is_b, input bit we, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [3:0] exp_we);
        gnt_t g;
        g.ga = ~is_b;
        g.gb = is_b;
        g.bs = addr[7:6];
        g.we = we ? exp_we : 4'h0;
        g.ra = addr[5:0];
        g.wd = wdata;
        gnt_q.push_back(g);
    endtask

    // One request: push expectations, hold req until own gnt, then drop it.
    task automatic xfer(input bit is_b, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [3:0] exp_we,
                        input bit exp_rsp, input logic [7:0] exp_rdata);
        bit got = 0;
        push_gnt(is_b, we, addr, wdata, exp_we);
        if (!we && exp_rsp) rsp_q.push_back({~is_b, is_b, exp_rdata});
        @(posedge clk); #1;
        set_req(is_b, 1'b1, we, addr, wdata);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (is_b ? bus.gntB : bus.gntA) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            fails++;
            checks++;
            $display("FAIL gnt_timeout actual=none required=gnt%s", is_b ? "B" : "A");
        end
        set_req(is_b, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    function automatic logic [31:0] outs();
        return {bus.gntA, bus.gntB, bus.rvalidA, bus.rvalidB, bus.rdata, bus.bankSel,
                bus.bankWe, bus.ramAddr, bus.ramWdata};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'hC1] = 8'h5A;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset, then reset again while idle
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("reset_outputs", 64'(outs()), 64'h0);
`ifdef ARB_GRANT_CNT_EN
        check("reset_cnt", {56'h0, grantCntA, grantCntB}, 64'h0);
`endif
        @(negedge clk); #2 rst = 1'b0;

        // A write 0x85 <- 0x3C, then held address/data after the pulse
        xfer(1'b0, 1'b1, 8'h85, 8'h3C, 4'b0100, 1'b0, 8'h00);
        @(negedge clk);
        check("hold_after_write", {44'h0, bus.bankSel, bus.ramAddr, bus.ramWdata, bus.bankWe},
              {44'h0, 2'b10, 6'h05, 8'h3C, 4'h0});

        // Read back what A wrote, then B reads the preloaded word
        xfer(1'b0, 1'b0, 8'h85, 8'h00, 4'h0, 1'b1, 8'h3C);
        xfer(1'b1, 1'b0, 8'hC1, 8'h00, 4'h0, 1'b1, 8'h5A);
        repeat (4) @(negedge clk);
        check("rdata_hold", {56'h0, bus.rdata}, {56'h0, 8'h5A});

        // Both requesters hold write requests: A,B,A,B
        push_gnt(1'b0, 1'b1, 8'h12, 8'h11, 4'b0001);
        push_gnt(1'b1, 1'b1, 8'h7F, 8'h22, 4'b0010);
        push_gnt(1'b0, 1'b1, 8'h12, 8'h11, 4'b0001);
        push_gnt(1'b1, 1'b1, 8'h7F, 8'h22, 4'b0010);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 8'h12, 8'h11);
        set_req(1'b1, 1'b1, 1'b1, 8'h7F, 8'h22);
        seen = 0;
        for (int n = 0; n < 40 && seen < 4; n++) begin
            @(negedge clk);
            if (bus.gntA | bus.gntB) seen++;
        end
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("tie_gnt_count", 64'(seen), 64'd4);
        repeat (3) @(negedge clk);
        check("mem_b_write", {56'h0, mem[8'h7F]}, {56'h0, 8'h22});

        // Reset during the read wait drops the command
        xfer(1'b1, 1'b0, 8'h40, 8'h00, 4'h0, 1'b0, 8'h00);
        #2 rst = 1'b1;
        #1 check("reset_midread", 64'(outs()), 64'h0);
        @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        xfer(1'b1, 1'b0, 8'hC1, 8'h00, 4'h0, 1'b1, 8'h5A);

        // 17 A writes and one B write since the last reset
        for (int i = 0; i < 17; i++) xfer(1'b0, 1'b1, 8'h20 + 8'(i), 8'(i), 4'b0001, 1'b0, 8'h00);
        xfer(1'b1, 1'b1, 8'hFF, 8'hEE, 4'b1000, 1'b0, 8'h00);
        xfer(1'b0, 1'b0, 8'h25, 8'h00, 4'h0, 1'b1, 8'h05);

        repeat (6) @(negedge clk);
        check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
`ifdef ARB_GRANT_CNT_EN
        check("grant_cnt_a_sat", {60'h0, grantCntA}, {60'h0, 4'hF});
        check("grant_cnt_b", {60'h0, grantCntB}, {60'h0, 4'h2});
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
